rom_fetch_unit: RTL and testbench
=================================

# rom_fetch_unit

Instruction fetch stage between the SM83 CPU core and the program ROM. On a fetch request it reads the opcode at PC and any immediate bytes it needs, 1–3 bytes in total, from the synchronous 1-cycle-latency program ROM. It then presents the complete assembled instruction to the decoder in one cycle. It is the sole driver of the ROM address and read-enable.

## Interface
Parameters
- `ADDR_W`, default 16: ROM address width; PC arithmetic wraps modulo 2^ADDR_W.

Ports
- `CLK` in 1: system clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `START` in 1: fetch request; sampled only in IDLE.
- `PC` in ADDR_W: opcode address; captured with START.
- `BUSY` out 1: high in any state other than IDLE.
- `VALID` out 1: one-cycle pulse; instruction outputs valid.
- `OPCODE` out 8: first byte fetched.
- `IMM` out 16: little-endian immediate; byte1 in [7:0], byte2 in [15:8]; unused bytes are 0.
- `LEN` out 2: instruction length 1..3.
- `CB_PREFIX` out 1: OPCODE == 0xCB; the suffix byte is in IMM[7:0].
- `NEXT_PC` out ADDR_W: (PC + LEN) mod 2^ADDR_W.
- `ILLEGAL` out 1: opcode is undefined on SM83 (see Configuration).
- `ROM_ADDR` out ADDR_W: program ROM address.
- `ROM_RE` out 1: ROM read enable.
- `ROM_DATA` in 8: ROM data; valid in the cycle after ROM_ADDR is presented.

## Operation
- State machine: IDLE → ISSUE → CAP_OP → [CAP_B1 → [CAP_B2]] → IDLE.
- IDLE
  - START=1: latch PC into `pc_q`, go to ISSUE.
- ISSUE
  - ROM_ADDR = pc_q.
- CAP_OP
  - ROM_DATA is the opcode; latch it.
  - ROM_ADDR = pc_q+1, presented speculatively.
  - Length is decoded combinationally from ROM_DATA.
  - LEN=1: return to IDLE and raise VALID. Otherwise go to CAP_B1.
- CAP_B1
  - Latch IMM[7:0]; ROM_ADDR = pc_q+2.
  - LEN=2: go to IDLE with VALID. Otherwise go to CAP_B2.
- CAP_B2
  - Latch IMM[15:8]; go to IDLE with VALID.
- ROM_RE = (state != IDLE). ROM_ADDR holds its last value in IDLE.
- Length table
  - 2-byte: 06 0E 16 1E 26 2E 36 3E, 10, 18 20 28 30 38, C6 CE D6 DE E6 EE F6 FE, E0 F0 E8 F8, CB.
  - 3-byte: 01 11 21 31, 08, C2 C3 C4 CA CC CD D2 D4 DA DC, EA FA.
  - All other opcodes are 1 byte.
- Address increments wrap: PC=0xFFFF fetches bytes from 0x0000 and 0x0001.
- START while BUSY is ignored; there is no queueing.
- START in the cycle VALID is high is accepted, because the state is IDLE.
- All outputs are registered except ROM_RE and ROM_ADDR, which are state-decoded from registers.
- Reset: RST forces IDLE from any state, including mid-fetch. Outputs reset to:
  - BUSY=0, VALID=0, ROM_RE=0
  - OPCODE=0, IMM=0, LEN=0, CB_PREFIX=0, ILLEGAL=0
  - NEXT_PC=0, ROM_ADDR=0
- After reset release, the first START is serviced normally; partial data is discarded.

## Timing
- START is sampled at edge E0.
  - ROM_ADDR=PC during cycle E0..E1.
  - The opcode is on ROM_DATA during E1..E2.
- VALID rises at edge E0+1+LEN and stays high exactly one cycle:
  - 1-byte instruction: 3 edges.
  - 2-byte instruction: 4 edges.
  - 3-byte instruction: 5 edges.
- OPCODE, IMM, LEN, CB_PREFIX, NEXT_PC and ILLEGAL update at the same edge as VALID and hold until the next VALID.
- Back-to-back throughput: a new START may be sampled in the VALID cycle, so the fetch period is 2+LEN cycles.

## Configuration
- `FETCH_ILLEGAL_DETECT_EN` defined:
  - ILLEGAL is set with VALID for opcodes D3 DB DD E3 E4 EB EC ED F4 FC FD.
  - These opcodes are treated as LEN=1.
- Not defined: ILLEGAL is tied to 0 and the detect logic is not compiled. Fetch behaviour is otherwise identical.

## Structure
- Package `fetch_pkg` holds:
  - state enum `fetch_state_t` (IDLE, ISSUE, CAP_OP, CAP_B1, CAP_B2);
  - function `sm83_len(opcode)` returning 2'd1..3;
  - function `sm83_illegal(opcode)`;
  - constant `CB_PREFIX_OP = 8'hCB`.
- One natural sub-module: `sm83_len_decode`, a combinational opcode → {LEN, ILLEGAL} decoder wrapping the package functions.

## Test plan
- NOP: ROM[0x0100]=00, START with PC=0x0100 → VALID at E0+2. Expect OPCODE=00, LEN=1, IMM=0000, NEXT_PC=0x0101.
- JP nn: ROM[0x0150..0x0152]=C3 50 01 → VALID at E0+4. Expect LEN=3, IMM=0x0150, NEXT_PC=0x0153; ROM_ADDR sequence 0150, 0151, 0152.
- CB BIT: ROM[0x0200..]=CB 7C → expect CB_PREFIX=1, LEN=2, IMM=0x007C, NEXT_PC=0x0202.
- Wrap: PC=0xFFFF, ROM[FFFF]=01, ROM[0000]=34, ROM[0001]=12 → expect IMM=0x1234, NEXT_PC=0x0002.
- Reset mid-fetch: RST asserted in CAP_B1 of an LD A,(nn) (FA) → immediately BUSY=0, ROM_RE=0, all outputs 0. A following NOP fetch completes correctly.
- With the macro defined, ROM=D3 → VALID with ILLEGAL=1, LEN=1. START issued while BUSY is ignored, with no extra VALID.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and SM83 opcode-length helpers for the ROM fetch unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    CAP_OP = 3'd2,
    CAP_B1 = 3'd3,
    CAP_B2 = 3'd4
  } fetch_state_t;

  localparam logic [7:0] CB_PREFIX_OP = 8'hCB;

  // Total instruction length in bytes (opcode plus immediates).
  function automatic logic [1:0] sm83_len(input logic [7:0] op);
    logic [1:0] len;
    case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h10,
      8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8,
      8'hCB:                                        len = 2'd2;
      8'h01, 8'h11, 8'h21, 8'h31,
      8'h08,
      8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC,
      8'hEA, 8'hFA:                                 len = 2'd3;
      default:                                      len = 2'd1;
    endcase
    return len;
  endfunction

  function automatic logic sm83_illegal(input logic [7:0] op);
    logic ill;
    case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: ill = 1'b1;
      default:                           ill = 1'b0;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/sm83_len_decode.sv
// Combinational opcode -> {length, illegal} decoder.
// Illegal-opcode flagging is compiled only with FETCH_ILLEGAL_DETECT_EN.
module sm83_len_decode
  import fetch_pkg::*;
(
  input  logic [7:0] op_i,
  output logic [1:0] len_o,
  output logic       illegal_o
);

`ifdef FETCH_ILLEGAL_DETECT_EN
  // Undefined opcodes are fetched as single bytes so the core can trap on them.
  assign illegal_o = sm83_illegal(op_i);
  assign len_o     = illegal_o ? 2'd1 : sm83_len(op_i);
`else
  assign illegal_o = 1'b0;
  assign len_o     = sm83_len(op_i);
`endif

endmodule

// File: rtl/rom_fetch_unit.sv
// SM83 instruction fetch: reads opcode + immediates from a 1-cycle ROM and
// presents the assembled instruction for one cycle. Optional: FETCH_ILLEGAL_DETECT_EN.
module rom_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] PC,
  output logic              BUSY,
  output logic              VALID,
  output logic [7:0]        OPCODE,
  output logic [15:0]       IMM,
  output logic [1:0]        LEN,
  output logic              CB_PREFIX,
  output logic [ADDR_W-1:0] NEXT_PC,
  output logic              ILLEGAL,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              ROM_RE,
  input  logic [7:0]        ROM_DATA
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, npc_q, npc_d;
  logic [7:0]        op_q, op_d, b1_q, b1_d, opcode_q, opcode_d;
  logic [1:0]        lenw_q, lenw_d, len_q, len_d;
  logic              illw_q, illw_d, ill_q, ill_d;
  logic [15:0]       imm_q, imm_d;
  logic              cb_q, cb_d, valid_q, valid_d, busy_q;
  logic [1:0]        dec_len;
  logic              dec_ill;

  sm83_len_decode u_dec (
    .op_i      (ROM_DATA),
    .len_o     (dec_len),
    .illegal_o (dec_ill)
  );

  function automatic logic [ADDR_W-1:0] pc_add(input logic [ADDR_W-1:0] a, input logic [1:0] n);
    return a + {{(ADDR_W-2){1'b0}}, n};
  endfunction

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    op_d     = op_q;
    b1_d     = b1_q;
    lenw_d   = lenw_q;
    illw_d   = illw_q;
    valid_d  = 1'b0;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    len_d    = len_q;
    cb_d     = cb_q;
    npc_d    = npc_q;
    ill_d    = ill_q;
    // addr_d is the address presented during the state being entered.
    case (state_q)
      IDLE: begin
        if (START) begin
          pc_d    = PC;
          addr_d  = PC;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        addr_d  = pc_add(pc_q, 2'd1);
        state_d = CAP_OP;
      end
      CAP_OP: begin
        op_d   = ROM_DATA;
        lenw_d = dec_len;
        illw_d = dec_ill;
        if (dec_len == 2'd1) begin
          valid_d  = 1'b1;
          opcode_d = ROM_DATA;
          imm_d    = 16'h0000;
          len_d    = 2'd1;
          cb_d     = (ROM_DATA == CB_PREFIX_OP);
          npc_d    = pc_add(pc_q, 2'd1);
          ill_d    = dec_ill;
          state_d  = IDLE;
        end else begin
          addr_d  = pc_add(pc_q, 2'd2);
          state_d = CAP_B1;
        end
      end
      CAP_B1: begin
        b1_d = ROM_DATA;
        if (lenw_q == 2'd2) begin
          valid_d  = 1'b1;
          opcode_d = op_q;
          imm_d    = {8'h00, ROM_DATA};
          len_d    = 2'd2;
          cb_d     = (op_q == CB_PREFIX_OP);
          npc_d    = pc_add(pc_q, 2'd2);
          ill_d    = illw_q;
          state_d  = IDLE;
        end else begin
          state_d = CAP_B2;
        end
      end
      CAP_B2: begin
        valid_d  = 1'b1;
        opcode_d = op_q;
        imm_d    = {ROM_DATA, b1_q};
        len_d    = 2'd3;
        cb_d     = (op_q == CB_PREFIX_OP);
        npc_d    = pc_add(pc_q, 2'd3);
        ill_d    = illw_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      addr_q   <= '0;
      op_q     <= '0;
      b1_q     <= '0;
      lenw_q   <= '0;
      illw_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      opcode_q <= '0;
      imm_q    <= '0;
      len_q    <= '0;
      cb_q     <= 1'b0;
      npc_q    <= '0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      op_q     <= op_d;
      b1_q     <= b1_d;
      lenw_q   <= lenw_d;
      illw_q   <= illw_d;
      valid_q  <= valid_d;
      busy_q   <= (state_d != IDLE);
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      len_q    <= len_d;
      cb_q     <= cb_d;
      npc_q    <= npc_d;
      ill_q    <= ill_d;
    end
  end

  assign BUSY      = busy_q;
  assign VALID     = valid_q;
  assign OPCODE    = opcode_q;
  assign IMM       = imm_q;
  assign LEN       = len_q;
  assign CB_PREFIX = cb_q;
  assign NEXT_PC   = npc_q;
  assign ILLEGAL   = ill_q;
  assign ROM_ADDR  = addr_q;
  assign ROM_RE    = (state_q != IDLE);

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed self-checking bench for rom_fetch_unit with a behavioural 1-cycle ROM.
module tb_rom_fetch_unit;

  logic        CLK, RST, START;
  logic [15:0] PC;
  logic        BUSY, VALID, CB_PREFIX, ILLEGAL, ROM_RE;
  logic [7:0]  OPCODE, ROM_DATA;
  logic [15:0] IMM, NEXT_PC, ROM_ADDR;
  logic [1:0]  LEN;

  logic [7:0]  mem [0:65535];
  logic [7:0]  rom_q;
  int          checks, errors;

`ifdef FETCH_ILLEGAL_DETECT_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  rom_fetch_unit #(.ADDR_W(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .PC(PC),
    .BUSY(BUSY), .VALID(VALID), .OPCODE(OPCODE), .IMM(IMM), .LEN(LEN),
    .CB_PREFIX(CB_PREFIX), .NEXT_PC(NEXT_PC), .ILLEGAL(ILLEGAL),
    .ROM_ADDR(ROM_ADDR), .ROM_RE(ROM_RE), .ROM_DATA(ROM_DATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) if (ROM_RE) rom_q <= mem[ROM_ADDR];
  assign ROM_DATA = rom_q;

  // Pulse START for one edge, then count edges until VALID (bounded).
  // a0..a2 are ROM_ADDR after edges E0, E1, E2. poke drives a stray START mid-fetch.
  task automatic do_fetch(input logic [15:0] pc, input logic poke, output int lat,
                          output logic [15:0] a0, output logic [15:0] a1, output logic [15:0] a2);
    @(negedge CLK); START = 1'b1; PC = pc;
    @(posedge CLK); #1; START = 1'b0; a0 = ROM_ADDR; a1 = '0; a2 = '0;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      if (poke && i == 0) begin START = 1'b1; PC = 16'h0100; end
      @(posedge CLK); #1;
      if (poke && i == 0) START = 1'b0;
      lat++;
      if (lat == 1) a1 = ROM_ADDR;
      if (lat == 2) a2 = ROM_ADDR;
      if (VALID) break;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; PC = '0;
    #1;
    checks++; if ({BUSY, VALID, ROM_RE} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b exp 000", {BUSY, VALID, ROM_RE}); end
    checks++; if ({OPCODE, IMM, LEN, CB_PREFIX, ILLEGAL} !== 28'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {OPCODE, IMM, LEN, CB_PREFIX, ILLEGAL}); end
    checks++; if ({NEXT_PC, ROM_ADDR} !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", {NEXT_PC, ROM_ADDR}); end
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_nop();
    int lat; logic [15:0] a0, a1, a2;
    mem[16'h0100] = 8'h00;
    do_fetch(16'h0100, 1'b0, lat, a0, a1, a2);
    checks++; if (lat !== 2) begin errors++; $display("FAIL nop_latency got %0d exp 2", lat); end
    checks++; if ({OPCODE, LEN, IMM} !== {8'h00, 2'd1, 16'h0000}) begin errors++; $display("FAIL nop_fields got %h/%0d/%h exp 00/1/0000", OPCODE, LEN, IMM); end
    checks++; if (NEXT_PC !== 16'h0101) begin errors++; $display("FAIL nop_next_pc got %h exp 0101", NEXT_PC); end
    @(posedge CLK); #1;
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL valid_pulse got %b exp 0", VALID); end
    checks++; if ({OPCODE, LEN, NEXT_PC} !== {8'h00, 2'd1, 16'h0101}) begin errors++; $display("FAIL nop_hold got %h/%0d/%h exp 00/1/0101", OPCODE, LEN, NEXT_PC); end
  endtask

  task automatic test_jp();
    int lat; logic [15:0] a0, a1, a2;
    mem[16'h0150] = 8'hC3; mem[16'h0151] = 8'h50; mem[16'h0152] = 8'h01;
    do_fetch(16'h0150, 1'b0, lat, a0, a1, a2);
    checks++; if (lat !== 4) begin errors++; $display("FAIL jp_latency got %0d exp 4", lat); end
    checks++; if ({LEN, IMM, NEXT_PC} !== {2'd3, 16'h0150, 16'h0153}) begin errors++; $display("FAIL jp_fields got %0d/%h/%h exp 3/0150/0153", LEN, IMM, NEXT_PC); end
    checks++; if ({a0, a1, a2} !== {16'h0150, 16'h0151, 16'h0152}) begin errors++; $display("FAIL jp_rom_addr got %h %h %h exp 0150 0151 0152", a0, a1, a2); end
    checks++; if ({OPCODE, CB_PREFIX, ILLEGAL} !== {8'hC3, 2'b00}) begin errors++; $display("FAIL jp_opcode got %h/%b/%b exp c3/0/0", OPCODE, CB_PREFIX, ILLEGAL); end
  endtask

  task automatic test_cb();
    int lat; logic [15:0] a0, a1, a2;
    mem[16'h0200] = 8'hCB; mem[16'h0201] = 8'h7C;
    do_fetch(16'h0200, 1'b0, lat, a0, a1, a2);
    checks++; if (lat !== 3) begin errors++; $display("FAIL cb_latency got %0d exp 3", lat); end
    checks++; if ({CB_PREFIX, LEN, IMM, NEXT_PC} !== {1'b1, 2'd2, 16'h007C, 16'h0202}) begin errors++; $display("FAIL cb_fields got %b/%0d/%h/%h exp 1/2/007c/0202", CB_PREFIX, LEN, IMM, NEXT_PC); end
  endtask

  task automatic test_wrap();
    int lat; logic [15:0] a0, a1, a2;
    mem[16'hFFFF] = 8'h01; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
    do_fetch(16'hFFFF, 1'b0, lat, a0, a1, a2);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wrap_latency got %0d exp 4", lat); end
    checks++; if ({IMM, NEXT_PC, LEN} !== {16'h1234, 16'h0002, 2'd3}) begin errors++; $display("FAIL wrap_fields got %h/%h/%0d exp 1234/0002/3", IMM, NEXT_PC, LEN); end
    checks++; if ({a0, a1, a2} !== {16'hFFFF, 16'h0000, 16'h0001}) begin errors++; $display("FAIL wrap_rom_addr got %h %h %h exp ffff 0000 0001", a0, a1, a2); end
  endtask

  task automatic test_illegal_and_busy();
    int lat; logic [15:0] a0, a1, a2; int extra;
    mem[16'h0400] = 8'hD3;
    do_fetch(16'h0400, 1'b0, lat, a0, a1, a2);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ill_latency got %0d exp 2", lat); end
    checks++; if ({OPCODE, LEN, ILLEGAL} !== {8'hD3, 2'd1, EXP_ILL}) begin errors++; $display("FAIL ill_fields got %h/%0d/%b exp d3/1/%b", OPCODE, LEN, ILLEGAL, EXP_ILL); end
    // Stray START one cycle into a JP fetch must be dropped.
    do_fetch(16'h0150, 1'b1, lat, a0, a1, a2);
    checks++; if ({lat, IMM, OPCODE} !== {32'd4, 16'h0150, 8'hC3}) begin errors++; $display("FAIL busy_ignore_fetch got %0d/%h/%h exp 4/0150/c3", lat, IMM, OPCODE); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (VALID || BUSY) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_ignore_extra got %0d exp 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] a0, a1, a2;
    mem[16'h0500] = 8'h3E; mem[16'h0501] = 8'h99; mem[16'h0502] = 8'h00;
    do_fetch(16'h0500, 1'b0, lat, a0, a1, a2);
    checks++; if ({lat, LEN, IMM, NEXT_PC} !== {32'd3, 2'd2, 16'h0099, 16'h0502}) begin errors++; $display("FAIL b2b_first got %0d/%0d/%h/%h exp 3/2/0099/0502", lat, LEN, IMM, NEXT_PC); end
    START = 1'b1; PC = 16'h0502;
    @(posedge CLK); #1; START = 1'b0;
    checks++; if ({BUSY, VALID, ROM_ADDR} !== {2'b10, 16'h0502}) begin errors++; $display("FAIL b2b_accept got %b%b/%h exp 10/0502", BUSY, VALID, ROM_ADDR); end
    lat = 0;
    for (int i = 0; i < 8; i++) begin @(posedge CLK); #1; lat++; if (VALID) break; end
    checks++; if ({lat, OPCODE, NEXT_PC, LEN} !== {32'd2, 8'h00, 16'h0503, 2'd1}) begin errors++; $display("FAIL b2b_second got %0d/%h/%h/%0d exp 2/00/0503/1", lat, OPCODE, NEXT_PC, LEN); end
  endtask

  task automatic test_reset_mid_fetch();
    int lat; logic [15:0] a0, a1, a2;
    mem[16'h0300] = 8'hFA; mem[16'h0301] = 8'h34; mem[16'h0302] = 8'h12;
    @(negedge CLK); START = 1'b1; PC = 16'h0300;
    @(posedge CLK); #1; START = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    checks++; if ({BUSY, ROM_RE, ROM_ADDR} !== {2'b11, 16'h0302}) begin errors++; $display("FAIL mid_in_b1 got %b%b/%h exp 11/0302", BUSY, ROM_RE, ROM_ADDR); end
    RST = 1'b1; #1;
    checks++; if ({BUSY, ROM_RE, VALID, ROM_ADDR} !== {3'b000, 16'h0000}) begin errors++; $display("FAIL mid_rst_ctl got %b%b%b/%h exp 000/0000", BUSY, ROM_RE, VALID, ROM_ADDR); end
    checks++; if ({OPCODE, IMM, LEN, CB_PREFIX, ILLEGAL, NEXT_PC} !== 44'h0) begin errors++; $display("FAIL mid_rst_data got %h exp 0", {OPCODE, IMM, LEN, CB_PREFIX, ILLEGAL, NEXT_PC}); end
    @(posedge CLK); @(negedge CLK); RST = 1'b0;
    do_fetch(16'h0100, 1'b0, lat, a0, a1, a2);
    checks++; if ({lat, OPCODE, LEN, IMM, NEXT_PC} !== {32'd2, 8'h00, 2'd1, 16'h0000, 16'h0101}) begin errors++; $display("FAIL mid_after_nop got %0d/%h/%0d/%h/%h exp 2/00/1/0000/0101", lat, OPCODE, LEN, IMM, NEXT_PC); end
  endtask

  initial begin
    checks = 0; errors = 0; rom_q = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_nop();
    test_jp();
    test_cb();
    test_wrap();
    test_illegal_and_busy();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
